// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed seven-segment scan controller with frame-synchronous commit.
// Optional leading-zero blanking is enabled by defining SEG_SCAN_LZB_EN.
module seg_scan_ctrl #(
  parameter int DIGITS = 4,
  parameter int DWELL  = 1000,
  parameter int BLANK  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     dp_mask,
  input  logic                  load,
  output logic [3:0]            bcd,
  output logic                  dp_n,
  output logic [DIGITS-1:0]     an_n,
  output logic                  frame_done,
  output logic                  pending
);

  localparam int CW = $clog2(DWELL);
  localparam int IW = $clog2(DIGITS);
  localparam logic [CW-1:0] CNT_BLANK_END = CW'(BLANK - 1);
  localparam logic [CW-1:0] CNT_SLOT_END  = CW'(DWELL - 1);
  localparam logic [IW-1:0] IDX_LAST      = IW'(DIGITS - 1);

  typedef enum logic [1:0] {ST_OFF, ST_BLANK, ST_SHOW} state_t;

  state_t                   state_q, state_d;
  logic [IW-1:0]            idx_q, idx_d;
  logic [CW-1:0]            cnt_q, cnt_d;
  logic [DIGITS-1:0][3:0]   disp_val_q, disp_val_d;
  logic [DIGITS-1:0]        disp_dp_q, disp_dp_d;
  logic [DIGITS-1:0][3:0]   pend_val_q, pend_val_d;
  logic [DIGITS-1:0]        pend_dp_q, pend_dp_d;
  logic                     pend_q, pend_d;
  logic [DIGITS-1:0]        an_n_q, an_n_d;
  logic [3:0]               bcd_q, bcd_d;
  logic                     dp_n_q, dp_n_d;
  logic                     frame_done_q, frame_done_d;
  logic                     commit;
  logic                     lzb_blank;

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    cnt_d        = cnt_q;
    disp_val_d   = disp_val_q;
    disp_dp_d    = disp_dp_q;
    pend_val_d   = pend_val_q;
    pend_dp_d    = pend_dp_q;
    pend_d       = pend_q;
    frame_done_d = 1'b0;
    commit       = 1'b0;
    case (state_q)
      ST_OFF: begin
        commit = pend_q;
        if (enable) begin
          state_d = ST_BLANK;
          idx_d   = '0;
          cnt_d   = '0;
        end
      end
      ST_BLANK: begin
        if (!enable) begin
          state_d = ST_OFF;
          idx_d   = '0;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_BLANK_END) state_d = ST_SHOW;
        end
      end
      ST_SHOW: begin
        if (!enable) begin
          state_d = ST_OFF;
          idx_d   = '0;
          cnt_d   = '0;
        end else if (cnt_q == CNT_SLOT_END) begin
          cnt_d   = '0;
          state_d = ST_BLANK;
          if (idx_q == IDX_LAST) begin
            // Frame boundary: the only place a running display swaps buffers.
            idx_d        = '0;
            frame_done_d = 1'b1;
            commit       = pend_q;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_OFF;
        idx_d   = '0;
        cnt_d   = '0;
      end
    endcase
    if (commit) begin
      disp_val_d = pend_val_q;
      disp_dp_d  = pend_dp_q;
      pend_d     = 1'b0;
    end
    // A load coinciding with a commit lands behind it and keeps pending set.
    if (load) begin
      pend_val_d = value;
      pend_dp_d  = dp_mask;
      pend_d     = 1'b1;
    end
  end

`ifdef SEG_SCAN_LZB_EN
  logic [DIGITS-1:0] upper_zero;

  always_comb begin
    logic z;
    z = 1'b1;
    upper_zero = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      z = z & (disp_val_d[i] == 4'd0);
      upper_zero[i] = z;
    end
  end

  assign lzb_blank = (idx_d != '0) && upper_zero[idx_d] && !disp_dp_d[idx_d];
`else
  assign lzb_blank = 1'b0;
`endif

  // Outputs are decoded from the next state so they are registered alongside it.
  always_comb begin
    an_n_d = '1;
    bcd_d  = '0;
    dp_n_d = 1'b1;
    if (state_d != ST_OFF) bcd_d = disp_val_d[idx_d];
    if (state_d == ST_SHOW && !lzb_blank) begin
      an_n_d[idx_d] = 1'b0;
      dp_n_d        = ~disp_dp_d[idx_d];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_OFF;
      idx_q        <= '0;
      cnt_q        <= '0;
      disp_val_q   <= '0;
      disp_dp_q    <= '0;
      pend_val_q   <= '0;
      pend_dp_q    <= '0;
      pend_q       <= 1'b0;
      an_n_q       <= '1;
      bcd_q        <= '0;
      dp_n_q       <= 1'b1;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      disp_val_q   <= disp_val_d;
      disp_dp_q    <= disp_dp_d;
      pend_val_q   <= pend_val_d;
      pend_dp_q    <= pend_dp_d;
      pend_q       <= pend_d;
      an_n_q       <= an_n_d;
      bcd_q        <= bcd_d;
      dp_n_q       <= dp_n_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign bcd        = bcd_q;
  assign dp_n       = dp_n_q;
  assign an_n       = an_n_q;
  assign frame_done = frame_done_q;
  assign pending    = pend_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl: directed scenarios plus random traffic, all checked
// against a frame-position model of the display.
module tb_seg_scan_ctrl;
  localparam int DIGITS = 4;
  localparam int DWELL  = 8;
  localparam int BLANK  = 2;
  localparam int FRAME  = DIGITS * DWELL;

  logic        clk = 1'b0;
  logic        reset, enable, load;
  logic [15:0] value;
  logic [3:0]  dp_mask;
  logic [3:0]  bcd;
  logic        dp_n;
  logic [3:0]  an_n;
  logic        frame_done, pending;

  seg_scan_ctrl #(.DIGITS(DIGITS), .DWELL(DWELL), .BLANK(BLANK)) dut (
    .clk(clk), .reset(reset), .enable(enable), .value(value), .dp_mask(dp_mask),
    .load(load), .bcd(bcd), .dp_n(dp_n), .an_n(an_n), .frame_done(frame_done),
    .pending(pending)
  );

  always #5 clk = ~clk;

  int nchk = 0;
  int nerr = 0;

  // model: running flag plus position within the frame
  bit          m_run, m_pend, m_fd;
  int          m_pos;
  logic [15:0] m_disp, m_pval;
  logic [3:0]  m_ddp, m_pdp;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  function automatic void m_reset();
    m_run = 0; m_pend = 0; m_fd = 0; m_pos = 0;
    m_disp = '0; m_pval = '0; m_ddp = '0; m_pdp = '0;
  endfunction

  function automatic void model_edge();
    bit commit;
    commit = 0;
    m_fd   = 0;
    if (reset) begin
      m_reset();
      return;
    end
    if (!m_run) begin
      commit = m_pend;
      if (enable) begin m_run = 1; m_pos = 0; end
    end else if (!enable) begin
      m_run = 0; m_pos = 0;
    end else if (m_pos == FRAME - 1) begin
      m_pos = 0; m_fd = 1; commit = m_pend;
    end else begin
      m_pos++;
    end
    if (commit) begin m_disp = m_pval; m_ddp = m_pdp; m_pend = 0; end
    if (load) begin m_pval = value; m_pdp = dp_mask; m_pend = 1; end
  endfunction

  task automatic check_outputs();
    int d;
    bit lit;
    logic [3:0] e_an, e_bcd;
    logic e_dp;
    d   = m_pos / DWELL;
    lit = m_run && ((m_pos % DWELL) >= BLANK);
`ifdef SEG_SCAN_LZB_EN
    if (lit && d != 0 && !m_ddp[d] && ((m_disp >> (4 * d)) == 16'h0)) lit = 0;
`endif
    e_an  = lit ? ~(4'b0001 << d) : 4'hF;
    e_bcd = m_run ? 4'((m_disp >> (4 * d)) & 16'hF) : 4'h0;
    e_dp  = lit ? ~m_ddp[d] : 1'b1;
    chk("an_n", 32'(an_n), 32'(e_an));
    chk("bcd", 32'(bcd), 32'(e_bcd));
    chk("dp_n", 32'(dp_n), 32'(e_dp));
    chk("frame_done", 32'(frame_done), 32'(m_fd));
    chk("pending", 32'(pending), 32'(m_pend));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_outputs();
    load = 1'b0;
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] d);
    value = v; dp_mask = d; load = 1'b1;
    step();
  endtask

  task automatic wait_pos(input int p);
    int n;
    n = 0;
    while (!(m_run && m_pos == p) && n < 200) begin step(); n++; end
    if (n >= 200) chk("wait_pos_timeout", 0, 1);
  endtask

  task automatic async_reset();
    #2 reset = 1'b1; enable = 1'b0;
    #1 m_reset();
    check_outputs();
    step();
    reset = 1'b0;
  endtask

  initial begin
    int n;
    reset = 1'b1; enable = 1'b0; load = 1'b0; value = '0; dp_mask = '0;
    m_reset();
    #12 check_outputs();
    @(negedge clk) reset = 1'b0;
    run(3);

    // load while off, then enable; digit 0 lights BLANK+1 edges later
    do_load(16'h1A3F, 4'b0100);
    run(2);
    chk("pend_committed_off", 32'(pending), 0);
    enable = 1'b1;
    run(3);
    chk("first_light", 32'(an_n), 32'(4'b1110));
    chk("first_bcd", 32'(bcd), 32'hF);
    n = 0;
    while (!frame_done && n < 100) begin step(); n++; end
    chk("fd_seen", 32'(frame_done), 1);
    run(FRAME);
    chk("fd_period", 32'(frame_done), 1);

    // load during digit 1; commit at the next boundary
    wait_pos(DWELL + 3);
    do_load(16'h0042, 4'b0000);
    wait_pos(2 * DWELL + 4);
    chk("old_digit2", 32'(bcd), 32'hA);
    chk("pend_held", 32'(pending), 1);
    wait_pos(0);
    chk("pend_clear_on_fd", 32'(pending), 0);
    run(FRAME + 4);

    // last load wins; load on the boundary cycle stays pending
    wait_pos(5);
    do_load(16'h1111, 4'b0000);
    run(3);
    do_load(16'h2222, 4'b0000);
    wait_pos(FRAME - 1);
    do_load(16'h3333, 4'b0000);
    chk("pend_boundary", 32'(pending), 1);
    run(BLANK);
    chk("show_2222", 32'(bcd), 32'h2);
    wait_pos(0);
    run(BLANK + 1);
    chk("show_3333", 32'(bcd), 32'h3);

    // drop enable during digit 2 show, then re-enable
    wait_pos(2 * DWELL + 4);
    enable = 1'b0;
    step();
    chk("drop_dark", 32'(an_n), 32'hF);
    chk("drop_no_fd", 32'(frame_done), 0);
    run(3);
    enable = 1'b1;
    run(3);
    chk("relight", 32'(an_n), 32'(4'b1110));

    // leading-zero patterns (model decides blanking per build)
    do_load(16'h0042, 4'b0000);
    run(2 * FRAME);
    do_load(16'h0000, 4'b0000);
    run(2 * FRAME);
    do_load(16'h0000, 4'b1000);
    run(2 * FRAME);

    // reset in mid-show
    wait_pos(5);
    async_reset();
    chk("rst_pending", 32'(pending), 0);
    run(4);

    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(39) == 0) enable = ~enable;
      if ($urandom_range(11) == 0) begin
        value   = ($urandom_range(2) == 0) ? 16'($urandom_range(255)) : 16'($urandom);
        dp_mask = ($urandom_range(1) == 0) ? 4'h0 : 4'($urandom);
        load    = 1'b1;
      end
      if ($urandom_range(699) == 0) async_reset();
      else step();
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/seg_scan_ctrl.md
# seg_scan_ctrl

Time-multiplexed scan controller that shares one hex-to-seven-segment decoder between DIGITS common-anode digits of the calculator display. It holds a double-buffered copy of the displayed value and steps through the digits with a programmable dwell time and an anti-ghosting blank interval. On each digit it drives the decoder's 4-bit input, the decimal point and the active-low anode enables. New values are committed only at frame boundaries, so a displayed frame never mixes old and new digits.

## Interface
- DIGITS, 4: number of display digits; legal range ≥2.
- DWELL, 1000: clock cycles per digit slot, including the blank interval.
- BLANK, 16: cycles at the start of each slot with all anodes off; legal range 1 ≤ BLANK < DWELL.

- clk  in  1  system clock
- reset  in  1  asynchronous, active-high
- enable  in  1  scan enable; when low, all digits are dark
- value  in  4*DIGITS  hex digits; nibble i is digit i, with digit 0 rightmost
- dp_mask  in  DIGITS  decimal-point-on per digit, active-high, captured with value
- load  in  1  single-cycle strobe that captures value/dp_mask into the pending register
- bcd  out  4  nibble to the shared decoder's b input
- dp_n  out  1  active-low decimal point, merged over decoder segment[7]
- an_n  out  DIGITS  active-low anode enables, at most one low
- frame_done  out  1  one-cycle pulse at the end of the last digit slot
- pending  out  1  a loaded value is waiting for commit

## Operation
- Registers: pending buffer (value and dp), display buffer, pending flag, digit index idx, slot counter cnt, and FSM state. All outputs are flops.
- Reset values: state OFF, idx 0, cnt 0, both buffers 0, pending 0, an_n all 1, bcd 0, dp_n 1, frame_done 0.
- FSM states:
  - OFF: an_n all 1. Any pending value commits to display on every cycle in this state. When enable is high, go to BLANK with idx 0 and cnt 0.
  - BLANK: an_n all 1. bcd = display nibble[idx], so the decoder settles before the anode turns on. cnt increments; at cnt = BLANK-1, go to SHOW.
  - SHOW: an_n[idx] = 0, bcd = nibble[idx], dp_n = ~dp[idx]. At cnt = DWELL-1: cnt goes to 0, idx increments, state goes to BLANK. When idx = DIGITS-1, idx wraps to 0 and frame_done pulses.
- Frame boundary (the SHOW→BLANK transition with idx = DIGITS-1): if pending is 1, display takes the pending buffer and pending clears.
- load:
  - Writes the pending buffer and sets pending.
  - A load while pending is already 1 overwrites the buffer; the last load wins.
  - A load on the frame-boundary cycle: the prior pending value commits, the new value lands in the pending buffer, and pending stays 1.
- enable low in BLANK or SHOW: the next state is OFF, idx and cnt go to 0, and an_n goes all 1 on that edge. frame_done does not pulse.
- Async reset in any state returns all registers to their reset values immediately. Any pending load is lost.

## Timing
- Slot length: exactly DWELL cycles, BLANK dark then DWELL-BLANK lit. Frame length: DIGITS*DWELL cycles.
- When enable is sampled high in OFF, an_n[0] goes low BLANK+1 edges later.
- bcd changes at the start of BLANK, never while an anode is low.
- frame_done is high for the single cycle after the boundary edge, coincident with the first BLANK cycle of digit 0.
- The commit is visible on the first lit cycle of the next frame.
- pending goes high the cycle after load and falls on the same edge that frame_done rises.

## Configuration
- SEG_SCAN_LZB_EN defined:
  - Leading-zero blanking: during SHOW, an_n[idx] stays 1 when idx ≠ 0 and display nibbles idx..DIGITS-1 are all 0.
  - A digit whose dp_mask bit is set is never blanked.
  - Slot timing and frame_done are unchanged.
- SEG_SCAN_LZB_EN undefined: every digit is lit in its slot.

## Test plan
All scenarios use DIGITS=4, DWELL=8, BLANK=2.
- Reset is asserted mid-SHOW. Required: an_n=4'b1111, bcd=0, dp_n=1, pending=0, frame_done=0 immediately. None of these change while enable is low.
- Load 16'h1A3F with dp_mask 4'b0100 while OFF, then enable. Required:
  - bcd sequence F,3,A,1; an_n sequence 1110,1101,1011,0111.
  - Each digit lit 6 cycles after 2 dark cycles.
  - dp_n=0 only on digit 2.
  - frame_done pulses every 32 cycles.
- With 1A3F showing, load 16'h0042 during digit 1. Required:
  - Digits 2 and 3 still show A,1 and pending=1.
  - pending clears on the frame_done cycle.
  - The next frame shows 2,4,0,0.
- Load 16'h1111, then 16'h2222 in the same frame, then 16'h3333 exactly on the boundary cycle. Required:
  - The next frame shows 2222.
  - pending stays 1.
  - The frame after shows 3333.
- Drop enable during digit 2 SHOW. Required:
  - an_n=1111 on the next cycle, with no frame_done.
  - On re-enable, digit 0 lights 3 edges later.
- With SEG_SCAN_LZB_EN defined:
  - Display 16'h0042: digits 2 and 3 stay dark for their full slots, and frame_done timing is unchanged.
  - Display 16'h0000: only digit 0 lights, showing '0'.
  - Display 16'h0000 with dp_mask 4'b1000: digits 0 and 3 light.
